// File: rtl/pad_mux_pkg.sv
// Shared types and defaults for the pad mux sequencer.
package pad_mux_pkg;

  localparam int PAD_N_IO_DEF      = 48;
  localparam int PAD_SEL_W         = 2;
  localparam int GATE_CYCLES_DEF   = 4;
  localparam int SETTLE_CYCLES_DEF = 4;

  typedef logic [PAD_SEL_W-1:0] pad_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2
  } pad_mux_state_e;

  // Counter width able to hold max_cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/pad_mux_delay_cnt.sv
// Loadable down-counter with a zero flag; shared by the GATE and SETTLE waits.
module pad_mux_delay_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pad_mux_sequencer.sv
// Per-pad mux-select owner applying break-before-make changes:
// gate OE, wait, switch select, wait, release gate.
// Optional macro PAD_MUX_LOCK_EN adds sticky per-pad locks (lock_set_i).
//
// state  | meaning
// IDLE   | ready for a request, no pad gated
// GATE   | target pad OE gated, select not yet switched
// SETTLE | select switched, OE still gated while the pad settles
module pad_mux_sequencer
  import pad_mux_pkg::*;
#(
  parameter int N_IO          = PAD_N_IO_DEF,
  parameter int NBIT_PADMUX   = PAD_SEL_W,
  parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  localparam int IDX_W        = $clog2(N_IO)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [IDX_W-1:0]                    wr_pad_i,
  input  logic [NBIT_PADMUX-1:0]              wr_sel_i,
  output logic                                wr_err_o,
  output logic                                busy_o,
`ifdef PAD_MUX_LOCK_EN
  input  logic [N_IO-1:0]                     lock_set_i,
`endif
  output logic [N_IO-1:0][NBIT_PADMUX-1:0]    pad_mux_o,
  output logic [N_IO-1:0]                     oe_gate_o
);

  localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = cnt_width(MAX_CYC);
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  // One extra bit so an out-of-range index equal to N_IO is representable.
  localparam logic [IDX_W:0]   N_IO_W      = (IDX_W + 1)'(N_IO);

  pad_mux_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                     pad_q, pad_d;
  logic [NBIT_PADMUX-1:0]               sel_q, sel_d;
  logic [N_IO-1:0][NBIT_PADMUX-1:0]     mux_q, mux_d;
  logic [N_IO-1:0]                      gate_q, gate_d;
  logic                                 err_q, err_d;
  logic                                 busy_q, busy_d;
  logic                                 cnt_load;
  logic [CNT_W-1:0]                     cnt_load_val;
  logic                                 cnt_zero;
  logic                                 pad_in_range;
  logic                                 pad_locked;

  assign pad_in_range = ({1'b0, wr_pad_i} < N_IO_W);

`ifdef PAD_MUX_LOCK_EN
  logic [N_IO-1:0] lock_q;

  // Sticky locks; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_q <= '0;
    else       lock_q <= lock_q | lock_set_i;
  end

  assign pad_locked = pad_in_range && lock_q[wr_pad_i];
`else
  assign pad_locked = 1'b0;
`endif

  // Sequencer next-state: accept/reject in IDLE, switch select at end of GATE,
  // release the gate at end of SETTLE.
  always_comb begin
    state_d      = state_q;
    pad_d        = pad_q;
    sel_d        = sel_q;
    mux_d        = mux_q;
    gate_d       = gate_q;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = GATE_LOAD;
    case (state_q)
      IDLE: begin
        if (wr_valid_i) begin
          if (!pad_in_range || pad_locked) begin
            err_d = 1'b1;
          end else if (wr_sel_i != mux_q[wr_pad_i]) begin
            pad_d            = wr_pad_i;
            sel_d            = wr_sel_i;
            gate_d[wr_pad_i] = 1'b1;
            cnt_load         = 1'b1;
            state_d          = GATE;
          end
        end
      end
      GATE: begin
        if (cnt_zero) begin
          mux_d[pad_q] = sel_q;
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          gate_d[pad_q] = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pad_q   <= '0;
      sel_q   <= '0;
      mux_q   <= '0;
      gate_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      sel_q   <= sel_d;
      mux_q   <= mux_d;
      gate_q  <= gate_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  pad_mux_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  assign wr_ready_o = (state_q == IDLE);
  assign busy_o     = busy_q;
  assign wr_err_o   = err_q;
  assign pad_mux_o  = mux_q;
  assign oe_gate_o  = gate_q;

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// Directed bench for pad_mux_sequencer (default parameters: 48 pads, 4+4 cycles).
module tb_pad_mux_sequencer;

  localparam int N_IO = 48;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [5:0]            wr_pad_i;
  logic [1:0]            wr_sel_i;
  logic                  wr_err_o;
  logic                  busy_o;
  logic [N_IO-1:0][1:0]  pad_mux_o;
  logic [N_IO-1:0]       oe_gate_o;
`ifdef PAD_MUX_LOCK_EN
  logic [N_IO-1:0]       lock_set_i;
`endif

  int checks = 0;
  int errors = 0;
  int cnt;
  logic [N_IO-1:0][1:0]  exp_mux;

  always #5 clk_i = ~clk_i;

  pad_mux_sequencer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_pad_i   (wr_pad_i),
    .wr_sel_i   (wr_sel_i),
    .wr_err_o   (wr_err_o),
    .busy_o     (busy_o),
`ifdef PAD_MUX_LOCK_EN
    .lock_set_i (lock_set_i),
`endif
    .pad_mux_o  (pad_mux_o),
    .oe_gate_o  (oe_gate_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_IO-1:0] onehot(input int i);
    logic [N_IO-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    rst_i      = 1'b1;
    wr_valid_i = 1'b0;
    wr_pad_i   = '0;
    wr_sel_i   = '0;
`ifdef PAD_MUX_LOCK_EN
    lock_set_i = '0;
`endif
    exp_mux    = '0;
    tick();
    tick();
    chk("rst_mux",   pad_mux_o,  exp_mux);
    chk("rst_gate",  oe_gate_o,  '0);
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_busy",  busy_o,     0);
    chk("rst_err",   wr_err_o,   0);
    rst_i = 1'b0;
    tick();

    // 1: pad 5 -> sel 2, gate for 8 cycles, select switches at t+5
    wr_valid_i = 1'b1; wr_pad_i = 6'd5; wr_sel_i = 2'd2;
    chk("t1_ready_pre", wr_ready_o, 1);
    tick();
    wr_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) exp_mux[5] = 2'd2;
      chk($sformatf("t1_gate_%0d", k),  oe_gate_o,  onehot(5));
      chk($sformatf("t1_mux_%0d", k),   pad_mux_o,  exp_mux);
      chk($sformatf("t1_ready_%0d", k), wr_ready_o, 0);
      chk($sformatf("t1_busy_%0d", k),  busy_o,     1);
      tick();
    end
    chk("t1_gate_end",  oe_gate_o,  '0);
    chk("t1_ready_end", wr_ready_o, 1);
    chk("t1_busy_end",  busy_o,     0);
    chk("t1_mux_end",   pad_mux_o,  exp_mux);

    // 2: same request again is a no-op
    wr_valid_i = 1'b1; wr_pad_i = 6'd5; wr_sel_i = 2'd2;
    tick();
    wr_valid_i = 1'b0;
    chk("t2_gate",  oe_gate_o,  '0);
    chk("t2_ready", wr_ready_o, 1);
    chk("t2_err",   wr_err_o,   0);
    chk("t2_mux",   pad_mux_o,  exp_mux);
    tick();
    chk("t2_gate2", oe_gate_o,  '0);

    // 3: out-of-range pad 48 -> single error pulse
    wr_valid_i = 1'b1; wr_pad_i = 6'd48; wr_sel_i = 2'd1;
    tick();
    wr_valid_i = 1'b0;
    chk("t3_err",   wr_err_o,   1);
    chk("t3_ready", wr_ready_o, 1);
    chk("t3_busy",  busy_o,     0);
    chk("t3_gate",  oe_gate_o,  '0);
    chk("t3_mux",   pad_mux_o,  exp_mux);
    tick();
    chk("t3_err_off", wr_err_o, 0);

    // 4: pad 7 held while busy on pad 3; gates never overlap
    wr_valid_i = 1'b1; wr_pad_i = 6'd3; wr_sel_i = 2'd1;
    tick();
    wr_pad_i = 6'd7; wr_sel_i = 2'd1;
    cnt = 0;
    while (busy_o && cnt < 20) begin
      chk("t4_gate_a", oe_gate_o, onehot(3));
      cnt++;
      tick();
    end
    chk("t4_len_a", cnt, 8);
    exp_mux[3] = 2'd1;
    chk("t4_gap_gate",  oe_gate_o,  '0);
    chk("t4_gap_ready", wr_ready_o, 1);
    chk("t4_mux_a",     pad_mux_o,  exp_mux);
    tick();
    wr_valid_i = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 20) begin
      chk("t4_gate_b", oe_gate_o, onehot(7));
      cnt++;
      tick();
    end
    chk("t4_len_b", cnt, 8);
    exp_mux[7] = 2'd1;
    chk("t4_mux_b",  pad_mux_o, exp_mux);
    chk("t4_gate_e", oe_gate_o, '0);

    // 5: reset in GATE cycle 3 on pad 10 aborts asynchronously
    wr_valid_i = 1'b1; wr_pad_i = 6'd10; wr_sel_i = 2'd3;
    tick();
    wr_valid_i = 1'b0;
    tick();
    tick();
    chk("t5_inflight", oe_gate_o, onehot(10));
    rst_i = 1'b1;
    #1;
    exp_mux = '0;
    chk("t5_mux",   pad_mux_o,  exp_mux);
    chk("t5_gate",  oe_gate_o,  '0);
    chk("t5_ready", wr_ready_o, 1);
    chk("t5_busy",  busy_o,     0);
    chk("t5_err",   wr_err_o,   0);
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    chk("t5_mux_post",  pad_mux_o, exp_mux);
    chk("t5_gate_post", oe_gate_o, '0);

`ifdef PAD_MUX_LOCK_EN
    // 6: locked pad 2 is rejected (even for a no-op select); pad 4 still works
    lock_set_i[2] = 1'b1;
    tick();
    lock_set_i = '0;
    wr_valid_i = 1'b1; wr_pad_i = 6'd2; wr_sel_i = 2'd3;
    tick();
    wr_valid_i = 1'b0;
    chk("t6_err",   wr_err_o,  1);
    chk("t6_gate",  oe_gate_o, '0);
    tick();
    chk("t6_err_off", wr_err_o,  0);
    chk("t6_mux",     pad_mux_o, exp_mux);
    wr_valid_i = 1'b1; wr_pad_i = 6'd2; wr_sel_i = 2'd0;
    tick();
    wr_valid_i = 1'b0;
    chk("t6_err_noop", wr_err_o, 1);
    tick();
    wr_valid_i = 1'b1; wr_pad_i = 6'd4; wr_sel_i = 2'd1;
    tick();
    wr_valid_i = 1'b0;
    chk("t6_gate4", oe_gate_o, onehot(4));
    cnt = 0;
    while (busy_o && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("t6_len", cnt, 8);
    exp_mux[4] = 2'd1;
    chk("t6_mux4", pad_mux_o, exp_mux);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
